// File: rtl/lsu_pkg.sv
// lsu_pkg: RV32I load/store encodings, error codes and byte-lane helpers for lsu32.
package lsu_pkg;
    typedef enum logic [2:0] {
        LSU_B  = 3'b000,
        LSU_H  = 3'b001,
        LSU_W  = 3'b010,
        LSU_BU = 3'b100,
        LSU_HU = 3'b101
    } lsu_size_t;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_ILLEGAL  = 2'b10,
        ERR_TIMEOUT  = 2'b11
    } lsu_err_t;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} lsu_state_t;

    function automatic logic [3:0] lsu_byte_mask(input logic [2:0] funct3, input logic [1:0] addr);
        return funct3[1:0] == 2'b00 ? 4'b0001 << addr :
               funct3[1:0] == 2'b01 ? 4'b0011 << addr : 4'b1111;
    endfunction

    function automatic logic [31:0] lsu_store_replicate(input logic [2:0] funct3, input logic [31:0] wdata);
        return funct3[1:0] == 2'b00 ? {4{wdata[7:0]}} :
               funct3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
    endfunction

    function automatic logic lsu_illegal(input logic [2:0] funct3, input logic is_store);
        return funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111 || (is_store && funct3[2]);
    endfunction

    function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [1:0] addr);
        return (funct3[1:0] == 2'b01 && addr[0]) || (funct3 == 3'b010 && addr != 2'b00);
    endfunction
endpackage

// File: rtl/memory_io_pkg.sv
// memory_io_pkg: 32-bit data memory request/response types shared by memory clients.
package memory_io_pkg;
    localparam int MEMORY_IO_TAG_W = 4;

    typedef struct packed {
        logic                       valid;
        logic [31:0]                addr;
        logic [3:0]                 do_read;
        logic [3:0]                 do_write;
        logic [31:0]                data;
        logic [MEMORY_IO_TAG_W-1:0] user_tag;
    } memory_io_req32;

    typedef struct packed {
        logic                       valid;
        logic [31:0]                data;
        logic [MEMORY_IO_TAG_W-1:0] user_tag;
    } memory_io_rsp32;

    localparam memory_io_req32 memory_io_no_req32 = '0;

    function automatic logic is_any_byte32(input logic [3:0] mask);
        return |mask;
    endfunction
endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: shifts the addressed bytes of a load word down and sign/zero-extends them.
module lsu_load_align import lsu_pkg::*; (
    input  logic [31:0] data_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);
    logic [31:0] sh;

    assign sh = data_i >> {off_i, 3'b000};

    always_comb begin
        data_o = funct3_i == LSU_B  ? {{24{sh[7]}}, sh[7:0]} :
                 funct3_i == LSU_H  ? {{16{sh[15]}}, sh[15:0]} :
                 funct3_i == LSU_BU ? {24'b0, sh[7:0]} :
                 funct3_i == LSU_HU ? {16'b0, sh[15:0]} : sh;
    end
endmodule

// File: rtl/lsu32.sv
// lsu32: single-outstanding RV32I load/store unit in front of the 32-bit data memory.
module lsu32 import lsu_pkg::*, memory_io_pkg::*; #(
    parameter int timeout_cycles = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           lsu_valid,
    output logic           lsu_ready,
    input  logic           lsu_is_store,
    input  logic [2:0]     lsu_funct3,
    input  logic [31:0]    lsu_addr,
    input  logic [31:0]    lsu_wdata,
    input  logic [4:0]     lsu_rd,
    output memory_io_req32 mem_req,
    input  memory_io_rsp32 mem_rsp,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [31:0]    res_data,
    output logic [4:0]     res_rd,
    output logic [1:0]     res_err
);
    localparam int CW = $clog2(timeout_cycles);

    lsu_state_t                 state_q;
    logic [2:0]                 funct3_q;
    logic [1:0]                 off_q;
    logic                       is_store_q;
    logic [MEMORY_IO_TAG_W-1:0] tag_q, itag_q;
    logic [CW-1:0]              cnt_q;
    memory_io_req32             mem_req_q, req_d;
    logic                       res_valid_q;
    logic [31:0]                res_data_q, load_d;
    logic [4:0]                 res_rd_q;
    lsu_err_t                   res_err_q;
    logic [3:0]                 mask_d;
    logic                       done_d;

    always_comb begin
        mask_d         = lsu_byte_mask(lsu_funct3, lsu_addr[1:0]);
        req_d          = memory_io_no_req32;
        req_d.valid    = 1'b1;
        req_d.addr     = lsu_addr;
        req_d.user_tag = tag_q;
        req_d.do_read  = lsu_is_store ? 4'b0 : mask_d;
        req_d.do_write = lsu_is_store ? mask_d : 4'b0;
        req_d.data     = lsu_is_store ? lsu_store_replicate(lsu_funct3, lsu_wdata) : 32'b0;
    end

    // Only the response carrying the tag we issued may complete the access.
    assign done_d = mem_rsp.valid && mem_rsp.user_tag == itag_q;

    lsu_load_align u_align (
        .data_i  (mem_rsp.data),
        .off_i   (off_q),
        .funct3_i(funct3_q),
        .data_o  (load_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            funct3_q    <= '0;
            off_q       <= '0;
            is_store_q  <= 1'b0;
            tag_q       <= '0;
            itag_q      <= '0;
            cnt_q       <= '0;
            mem_req_q   <= memory_io_no_req32;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_rd_q    <= '0;
            res_err_q   <= ERR_OK;
        end else begin
            mem_req_q <= memory_io_no_req32;
            case (state_q)
                S_IDLE: if (lsu_valid) begin
                    funct3_q   <= lsu_funct3;
                    off_q      <= lsu_addr[1:0];
                    is_store_q <= lsu_is_store;
                    res_rd_q   <= lsu_rd;
                    res_data_q <= '0;
                    if (lsu_illegal(lsu_funct3, lsu_is_store)) begin
                        res_err_q   <= ERR_ILLEGAL;
                        res_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else if (lsu_misaligned(lsu_funct3, lsu_addr[1:0])) begin
                        res_err_q   <= ERR_MISALIGN;
                        res_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        mem_req_q <= req_d;
                        itag_q    <= tag_q;
                        tag_q     <= tag_q + 1'b1;
                        cnt_q     <= '0;
                        state_q   <= S_WAIT;
                    end
                end
                S_WAIT: if (done_d) begin
                    res_data_q  <= is_store_q ? '0 : load_d;
                    res_err_q   <= ERR_OK;
                    res_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end else if (cnt_q == CW'(timeout_cycles - 1)) begin
                    res_data_q  <= '0;
                    res_err_q   <= ERR_TIMEOUT;
                    res_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                S_RESP: if (res_ready) begin
                    res_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign lsu_ready = state_q == S_IDLE;
    assign mem_req   = mem_req_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_rd    = res_rd_q;
    assign res_err   = res_err_q;
endmodule
